// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP responder: the 16 IEEE 1149.1
// controller states, the supported instruction codes and the data-register selection.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  localparam logic [4:0] INSTR_IDCODE = 5'h01;
  localparam logic [4:0] INSTR_USER   = 5'h10;
  localparam logic [4:0] INSTR_BYPASS = 5'h1F;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller next-state logic; the state only moves when
// 'advance' flags a detected TCK rising edge.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  tap_state_t state,
  input  logic       tms,
  input  logic       advance,
  output tap_state_t next_state
);

  always_comb begin
    next_state = state;
    if (advance) begin
      case (state)
        TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    next_state = tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        next_state = tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       next_state = tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         next_state = tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         next_state = tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         next_state = tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         next_state = tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        next_state = tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       next_state = tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         next_state = tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         next_state = tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         next_state = tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         next_state = tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        next_state = tms ? SELECT_DR : RUN_TEST_IDLE;
        default:          next_state = TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP responder: oversamples the JTAG pins on clk, runs the TAP controller
// and exposes IDCODE, a 32-bit USER data register and BYPASS.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1BEEF001,
  parameter int          IR_LEN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  input  logic        trst_n,
  output logic        tdo,
  output logic        tdo_oe,
  input  logic [31:0] user_rd_data,
  output logic [31:0] user_wr_data,
  output logic        user_wr_stb
);

  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(INSTR_IDCODE);
  localparam logic [IR_LEN-1:0] IR_USER   = IR_LEN'(INSTR_USER);

  // Pin order in the synchroniser vectors: {trst_n, tdi, tms, tck}
  logic [3:0] sync_meta, sync_pins;
  logic       tck_prev;
  logic       tck_rise, tck_fall, tms_s, tdi_s, trst_s_n;

  tap_state_t        state, state_next;
  logic [IR_LEN-1:0] ir, ir_shift;
  logic [31:0]       dr_shift;
  logic              bypass_reg;
  dr_sel_t           dr_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 4'b0010;
      sync_pins <= 4'b0010;
      tck_prev  <= 1'b0;
    end else begin
      sync_meta <= {trst_n, tdi, tms, tck};
      sync_pins <= sync_meta;
      tck_prev  <= sync_pins[0];
    end
  end

  assign tck_rise = sync_pins[0] & ~tck_prev;
  assign tck_fall = ~sync_pins[0] & tck_prev;
  assign tms_s    = sync_pins[1];
  assign tdi_s    = sync_pins[2];
  assign trst_s_n = sync_pins[3];

  // Unknown instruction codes fall back to BYPASS.
  always_comb begin
    if (ir == IR_IDCODE)    dr_sel = DR_IDCODE;
    else if (ir == IR_USER) dr_sel = DR_USER;
    else                    dr_sel = DR_BYPASS;
  end

  jtag_tap_fsm u_fsm (
    .state     (state),
    .tms       (tms_s),
    .advance   (tck_rise),
    .next_state(state_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= TEST_LOGIC_RESET;
      ir           <= IR_IDCODE;
      ir_shift     <= '0;
      dr_shift     <= '0;
      bypass_reg   <= 1'b0;
      tdo          <= 1'b0;
      tdo_oe       <= 1'b0;
      user_wr_data <= '0;
      user_wr_stb  <= 1'b0;
    end else begin
      user_wr_stb <= 1'b0;
      // TRST takes priority over any TCK edge seen in the same cycle.
      if (!trst_s_n) begin
        state      <= TEST_LOGIC_RESET;
        ir         <= IR_IDCODE;
        ir_shift   <= '0;
        dr_shift   <= '0;
        bypass_reg <= 1'b0;
        tdo        <= 1'b0;
        tdo_oe     <= 1'b0;
      end else begin
        state <= state_next;
        if (state == TEST_LOGIC_RESET) ir <= IR_IDCODE;

        if (tck_rise) begin
          case (state)
            CAPTURE_IR: ir_shift <= IR_LEN'(1);
            SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
            CAPTURE_DR: begin
              case (dr_sel)
                DR_IDCODE: dr_shift <= IDCODE;
                DR_USER:   dr_shift <= user_rd_data;
                default:   bypass_reg <= 1'b0;
              endcase
            end
            SHIFT_DR: begin
              if (dr_sel == DR_BYPASS) bypass_reg <= tdi_s;
              else                     dr_shift   <= {tdi_s, dr_shift[31:1]};
            end
            default: ;
          endcase
        end

        // TDO and register updates happen on the falling TCK edge.
        if (tck_fall) begin
          tdo_oe <= (state == SHIFT_IR) || (state == SHIFT_DR);
          case (state)
            SHIFT_IR: tdo <= ir_shift[0];
            SHIFT_DR: tdo <= (dr_sel == DR_BYPASS) ? bypass_reg : dr_shift[0];
            UPDATE_IR: begin
              tdo <= 1'b0;
              ir  <= ir_shift;
            end
            UPDATE_DR: begin
              tdo <= 1'b0;
              if (dr_sel == DR_USER) begin
                user_wr_data <= dr_shift;
                user_wr_stb  <= 1'b1;
              end
            end
            default: tdo <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/jtag_tap_responder.md
JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 Parameter IDCODE, default 32'h1BEEF001, value returned by IDCODE instruction; bit0 SHALL be 1.
REQ-002 Parameter IR_LEN, default 5, instruction register width.
REQ-003 Port clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port tck  input  1  JTAG TCK from initiator, asynchronous to clk.
REQ-006 Port tms  input  1  JTAG TMS.
REQ-007 Port tdi  input  1  JTAG TDI.
REQ-008 Port trst_n  input  1  JTAG TRST, active-low.
REQ-009 Port tdo  output  1  JTAG TDO data.
REQ-010 Port tdo_oe  output  1  high while in Shift-IR or Shift-DR.
REQ-011 Port user_rd_data  input  32  value captured into USER DR at Capture-DR.
REQ-012 Port user_wr_data  output  32  USER DR contents after Update-DR.
REQ-013 Port user_wr_stb  output  1  one-clk pulse when user_wr_data updated.

Function
REQ-014 tck, tms, tdi, trst_n SHALL pass through 2-flop synchronisers; TCK rise/fall detected from synchronised history; clk SHALL be >= 4x TCK frequency.
REQ-015 On each detected TCK rise, TAP SHALL advance per IEEE 1149.1 16-state FSM (Test-Logic-Reset, Run-Test-Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR) using synchronised tms.
REQ-016 Five consecutive TCK rises with tms=1 SHALL reach Test-Logic-Reset from any state.
REQ-017 Test-Logic-Reset SHALL load IR with IDCODE instruction (5'h01).
REQ-018 Instructions: 5'h01 IDCODE (32-bit), 5'h10 USER (32-bit), 5'h1F BYPASS (1-bit); any other code SHALL select BYPASS.
REQ-019 Capture-IR SHALL load IR shift register with 5'b00001; Capture-DR SHALL load IDCODE, user_rd_data, or 0 per selected DR.
REQ-020 In Shift-IR/Shift-DR, on TCK rise, shift register SHALL shift right, tdi entering MSB.
REQ-021 tdo SHALL update on TCK fall to current shift-register LSB; outside shift states tdo SHALL be 0 and tdo_oe 0.
REQ-022 Update-IR SHALL copy IR shift register into active IR on TCK fall.
REQ-023 Update-DR with USER selected SHALL copy USER shift register to user_wr_data and pulse user_wr_stb for exactly one clk; no pulse for other instructions.
REQ-024 Shift length not a multiple of register width: registers SHALL hold whatever was shifted; no error state.
REQ-025 Simultaneous TCK edge and synchronised trst_n low: trst_n SHALL win, TAP to Test-Logic-Reset.

Reset
REQ-026 rst or synchronised trst_n low SHALL force TAP to Test-Logic-Reset, IR=5'h01, shift registers 0.
REQ-027 On rst: tdo=0, tdo_oe=0, user_wr_data=0, user_wr_stb=0; trst_n SHALL NOT clear user_wr_data.
REQ-028 Reset assertion mid-shift SHALL abort the shift with no user_wr_stb.

Structure
REQ-029 Package jtag_tap_pkg SHALL hold tap_state_t enum (16 states) and instruction constants IDCODE/USER/BYPASS.
REQ-030 TAP next-state logic SHALL be sub-module jtag_tap_fsm (state, tms, advance in; state out).
REQ-031 Block SHALL be instantiable in sim_main in place of a DUT TAP, driven by SimJTAG tck/tms/tdi/trst_n.

Verification
REQ-032 rst release, TMS=1 x5, Shift-DR 32 bits -> tdo sequence equals 32'h1BEEF001 LSB first.
REQ-033 Shift-IR 5'h1F, Shift-DR 1 then 8 bits 8'hA5 -> tdo = 0 followed by A5 delayed one bit.
REQ-034 IR 5'h10, user_rd_data=32'hDEADBEEF, shift in 32'h12345678 -> tdo yields DEADBEEF; after Update-DR user_wr_data=12345678, user_wr_stb one clk.
REQ-035 trst_n low mid Shift-DR of USER -> Test-Logic-Reset, IR=01, no user_wr_stb, tdo_oe=0.
REQ-036 From each of 16 states, 5 TCK with TMS=1 -> Test-Logic-Reset; IR code 5'h07 -> BYPASS behaviour.
REQ-037 TCK at clk/4 with random TMS/TDI vs reference TAP model -> tdo bit-exact, no missed edges.
